seg_scan_decoder: RTL and testbench

Receive-side counterpart of the board's multiplexed 4-digit 7-segment driver. It watches the active-low an/seg scan bus and filters out scan transitions. It latches each digit's segment pattern and decodes it back to a hex nibble plus decimal point. It signals when a full 4-digit frame has been observed. Used as a loopback checker and as a decoder for display traffic mirrored from another board.

---
 rtl/seg_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit active-low 7-segment scan bus.
// Filters scan transitions, latches per-digit patterns, decodes hex glyphs and tracks frames.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [31:0] raw,
  output logic [15:0] hex,
  output logic [3:0]  hex_valid,
  output logic [3:0]  dp,
  output logic [3:0]  seen,
  output logic        frame_done,
  output logic        err
);

  localparam logic [7:0] QualCnt = 8'(STABLE_CYCLES - 2);
  localparam logic [7:0] SatCnt  = 8'(STABLE_CYCLES);

  logic [11:0] samp_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] raw_q;
  logic [15:0] hex_q;
  logic [3:0]  hex_valid_q, dp_q, seen_q, seen_or;
  logic        frame_done_q, err_q;

  logic        qualify, is_digit, is_blank;
  logic [1:0]  idx;
  logic [7:0]  seg_hi;
  logic [4:0]  dec;

  // Returns {valid, nibble} for an active-high pattern with bit0 = segment a.
  function automatic logic [4:0] glyph_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Qualify exactly once per stable period: on the cnt step S-2 -> S-1.
  always_comb begin
    qualify = (samp_q == prev_q) && (cnt_q == QualCnt);
    if (samp_q != prev_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q < SatCnt) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    is_digit = 1'b1;
    is_blank = 1'b0;
    idx      = 2'd0;
    case (samp_q[11:8])
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      4'b1111: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
    seg_hi  = ~samp_q[7:0];
    dec     = glyph_decode(seg_hi[6:0]);
    seen_or = seen_q | (4'b0001 << idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q       <= 12'hFFF;
      prev_q       <= 12'hFFF;
      cnt_q        <= 8'd0;
      raw_q        <= 32'd0;
      hex_q        <= 16'd0;
      hex_valid_q  <= 4'd0;
      dp_q         <= 4'd0;
      seen_q       <= 4'd0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      samp_q       <= {an, seg};
      prev_q       <= samp_q;
      cnt_q        <= cnt_d;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      if (qualify) begin
        if (is_digit) begin
          raw_q[{idx, 3'b000} +: 8] <= seg_hi;
          hex_q[{idx, 2'b00} +: 4]  <= dec[3:0];
          hex_valid_q[idx]          <= dec[4];
          dp_q[idx]                 <= seg_hi[7];
          if (&seen_or) begin
            frame_done_q <= 1'b1;
            seen_q       <= 4'd0;
          end else begin
            seen_q <= seen_or;
          end
        end else if (!is_blank) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign raw        = raw_q;
  assign hex        = hex_q;
  assign hex_valid  = hex_valid_q;
  assign dp         = dp_q;
  assign seen       = seen_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: run-length reference model plus directed
// literal checks and randomized scan traffic.
module tb_seg_scan_decoder;

  localparam int unsigned S = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an    = 4'hF;
  logic [7:0]  seg   = 8'hFF;
  logic [31:0] raw;
  logic [15:0] hex;
  logic [3:0]  hex_valid, dp, seen;
  logic        frame_done, err;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .an         (an),
    .seg        (seg),
    .raw        (raw),
    .hex        (hex),
    .hex_valid  (hex_valid),
    .dp         (dp),
    .seen       (seen),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int err_cnt  = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: tracks the run length of the sampled bus value; a run reaching
  // exactly S samples applies its event on the following clock edge.
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]  m_raw [4];
  logic [3:0]  m_hex [4];
  logic [3:0]  m_hv, m_dp, m_seen;
  logic        m_fd, m_err;
  logic [11:0] last_v;
  int          run;
  bit          pend;

  task automatic model_apply(input logic [11:0] v);
    logic [3:0] a;
    logic [7:0] s;
    int         d;
    a = v[11:8];
    s = ~v[7:0];
    d = -1;
    for (int i = 0; i < 4; i++) if (a == ~(4'b0001 << i)) d = i;
    if (d >= 0) begin
      m_raw[d] = s;
      m_dp[d]  = s[7];
      m_hex[d] = 4'h0;
      m_hv[d]  = 1'b0;
      for (int g = 0; g < 16; g++) begin
        if (glyph[g] == s[6:0]) begin
          m_hex[d] = 4'(g);
          m_hv[d]  = 1'b1;
        end
      end
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
        m_fd   = 1'b1;
        m_seen = 4'h0;
      end
    end else if (a != 4'hF) begin
      m_err = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          m_raw[i] = 8'h0;
          m_hex[i] = 4'h0;
        end
        m_hv   = 4'h0;
        m_dp   = 4'h0;
        m_seen = 4'h0;
        m_fd   = 1'b0;
        m_err  = 1'b0;
        last_v = 12'hFFF;
        run    = S + 1;
        pend   = 1'b0;
      end else begin
        m_fd  = 1'b0;
        m_err = 1'b0;
        if (pend) model_apply(last_v);
        if ({an, seg} == last_v) begin
          if (run <= S) run++;
        end else begin
          run    = 1;
          last_v = {an, seg};
        end
        pend = (run == S);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        check("raw", raw, {m_raw[3], m_raw[2], m_raw[1], m_raw[0]});
        check("hex", {16'h0, hex}, {16'h0, m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
        check("hex_valid", {28'h0, hex_valid}, {28'h0, m_hv});
        check("dp", {28'h0, dp}, {28'h0, m_dp});
        check("seen", {28'h0, seen}, {28'h0, m_seen});
        check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
        check("err", {31'h0, err}, {31'h0, m_err});
        check("fd_err_excl", {31'h0, frame_done & err}, 32'h0);
      end
      if (frame_done) fd_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clock);
  endtask

  int fd0, e0;

  initial begin
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    @(negedge clock);
    check("rst_raw", raw, 32'h0);
    check("rst_seen", {28'h0, seen}, 32'h0);
    reset = 1'b0;

    // Single capture of 'b' on digit 3
    fd0 = fd_cnt;
    hold(4'b0111, 8'b1000_0011, 10);
    check("d3_raw", {24'h0, raw[31:24]}, 32'h7C);
    check("d3_hex", {28'h0, hex[15:12]}, 32'hB);
    check("d3_hv", {31'h0, hex_valid[3]}, 32'h1);
    check("d3_dp", {31'h0, dp[3]}, 32'h0);
    check("d3_seen", {28'h0, seen}, 32'h8);
    check("d3_nofd", fd_cnt - fd0, 0);

    // Non-hex glyph 'o' on digit 2
    hold(4'b1011, 8'b1010_0011, 10);
    check("d2_raw", {24'h0, raw[23:16]}, 32'h5C);
    check("d2_hv", {31'h0, hex_valid[2]}, 32'h0);
    check("d2_hex", {28'h0, hex[11:8]}, 32'h0);

    // Full scan with decimal points
    fd0 = fd_cnt;
    hold(4'b0111, 8'h10, 10);
    hold(4'b1011, 8'h08, 10);
    hold(4'b1101, 8'h07, 10);
    hold(4'b1110, 8'h06, 10);
    check("scan_raw", raw, 32'hEFF7F8F9);
    check("scan_hex", {16'h0, hex}, 32'h9A0E);
    check("scan_hv", {28'h0, hex_valid}, 32'hD);
    check("scan_dp", {28'h0, dp}, 32'hF);
    check("scan_fd_once", fd_cnt - fd0, 1);
    check("scan_seen", {28'h0, seen}, 32'h0);

    // Illegal anode, then a too-short digit between blanking
    e0 = err_cnt;
    hold(4'b0011, 8'hC0, 8);
    check("err_once", err_cnt - e0, 1);
    check("err_raw", raw, 32'hEFF7F8F9);
    check("err_seen", {28'h0, seen}, 32'h0);
    hold(4'b1111, 8'hFF, 6);
    hold(4'b0111, 8'h00, 3);
    hold(4'b1111, 8'hFF, 6);
    check("glitch_err", err_cnt - e0, 1);
    check("glitch_raw", raw, 32'hEFF7F8F9);
    check("glitch_seen", {28'h0, seen}, 32'h0);

    // Recapture within a frame
    fd0 = fd_cnt;
    hold(4'b0111, 8'hC0, 10);
    hold(4'b0111, 8'hF9, 10);
    hold(4'b1011, 8'hC0, 10);
    hold(4'b1101, 8'hC0, 10);
    hold(4'b1110, 8'hC0, 10);
    check("recap_fd", fd_cnt - fd0, 1);
    check("recap_raw3", {24'h0, raw[31:24]}, 32'h06);
    check("recap_hex3", {28'h0, hex[15:12]}, 32'h1);

    // Reset lands on the edge where the 4th digit qualifies
    fd0 = fd_cnt;
    hold(4'b0111, 8'hC0, 10);
    hold(4'b1011, 8'hC0, 10);
    hold(4'b1101, 8'hC0, 10);
    check("pre_rst_seen", {28'h0, seen}, 32'hE);
    hold(4'b1110, 8'hC0, S);
    reset = 1'b1;
    @(negedge clock);
    check("rst_cap_raw", raw, 32'h0);
    check("rst_cap_hex", {16'h0, hex}, 32'h0);
    check("rst_cap_flags", {16'h0, hex_valid, dp, seen, 2'b00, frame_done, err}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_cap_nofd", fd_cnt - fd0, 0);

    // Randomized scan traffic checked by the model
    for (int k = 0; k < 400; k++) begin
      int         sel;
      logic [3:0] a;
      logic [7:0] s;
      sel = int'($urandom_range(0, 5));
      if (sel < 4) a = ~(4'b0001 << sel);
      else if (sel == 4) a = 4'hF;
      else a = 4'($urandom);
      if ($urandom_range(0, 1) == 0) s = ~{1'($urandom), glyph[$urandom_range(0, 15)]};
      else s = 8'($urandom);
      hold(a, s, int'($urandom_range(1, 8)));
    end
    hold(4'hF, 8'hFF, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
